fir_sequencer: RTL
==================

FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4, the number of filter taps (2..8).
REQ-002 SHALL have port clk  in  1  system clock, rising edge.
REQ-003 SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have port data_ready  in  1  one-cycle pulse: new sample present on sample_data.
REQ-005 SHALL have port sample_data  in  16  unsigned sample.
REQ-006 SHALL have port load_coeff  in  1  level: new coefficient set pending.
REQ-007 SHALL have port coeff_in  in  16  coefficient addressed by coeff_sel, unsigned Q1.15.
REQ-008 SHALL have port coeff_sel  out  $clog2(NUM_TAPS)  coefficient index being fetched.
REQ-009 SHALL have port coeff_done  out  1  one-cycle pulse: coefficient set latched.
REQ-010 SHALL have port busy  out  1  high while a load or computation is in progress.
REQ-011 SHALL have port fir_out  out  16  filter result.
REQ-012 SHALL have port out_valid  out  1  one-cycle pulse: fir_out updated.
REQ-013 SHALL have port err  out  1  overflow/overrun flag of the last result.
REQ-014 SHALL have port one_k_samples  out  1  one-cycle pulse every 1000th accepted sample.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, MAC, DONE.
REQ-016 In IDLE, load_coeff=1 SHALL move to LOAD; load_coeff has priority over a simultaneous data_ready, and that data_ready is dropped with overrun.
REQ-017 LOAD SHALL last NUM_TAPS cycles, driving coeff_sel 0..NUM_TAPS-1 and latching coeff_in into coefficient register k each cycle; coeff_done SHALL pulse on the last LOAD cycle, then IDLE.
REQ-018 In IDLE, data_ready=1 with load_coeff=0 SHALL accept sample_data and enter SHIFT.
REQ-019 SHIFT (1 cycle) SHALL shift the sample buffer: tap0 <= sample, tap k <= tap k-1, oldest sample discarded.
REQ-020 MAC SHALL last NUM_TAPS cycles; cycle k adds coeff[k]*tap[k] (32-bit product) into an accumulator of 32+$clog2(NUM_TAPS) bits, cleared in SHIFT.
REQ-021 DONE (1 cycle) SHALL register fir_out = accumulator >> 15, pulse out_valid, update err, then return to IDLE.
REQ-022 Latency SHALL be data_ready at cycle N, out_valid high at cycle N+NUM_TAPS+2 (6 for NUM_TAPS=4).
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 data_ready while not IDLE SHALL be ignored and SHALL set an overrun flag, folded into err at the next DONE.
REQ-025 err at DONE SHALL equal (accumulator>>15 > 16'hFFFF) OR overrun; overrun clears at DONE.
REQ-026 load_coeff rising while busy SHALL be held pending and serviced from IDLE after the current DONE.
REQ-027 The sample counter SHALL increment per accepted sample, wrap 999->0, and pulse one_k_samples in the cycle it wraps.

Reset
REQ-028 n_rst low SHALL asynchronously force state IDLE and clear the sample buffer, coefficient registers, accumulator, counter and overrun.
REQ-029 n_rst low SHALL force all outputs to 0, including mid-LOAD and mid-MAC, with no out_valid or coeff_done emitted afterwards for the aborted operation.

Configuration
REQ-030 With FIR_SATURATE_EN defined, overflow SHALL clamp fir_out to 16'hFFFF.
REQ-031 Without FIR_SATURATE_EN, overflow SHALL output the low 16 bits of accumulator>>15; err SHALL be identical in both builds.

Structure
REQ-032 Package fir_pkg SHALL hold the state enum, NUM_TAPS default, sample/coefficient widths (16), the fraction shift (15) and the wrap count (1000).
REQ-033 The multiply-accumulate SHALL be a sub-module fir_mac (clear, enable, coeff, sample -> accumulator).

Verification
REQ-034 Load coeffs all 16'h8000, then send samples 100, 200 -> fir_out 100, then 300, err=0, out_valid 6 cycles after each data_ready.
REQ-035 Load coeffs 16'hFFFF x4, then send samples 60000 x4 -> 4th result err=1; fir_out 16'hFFFF with FIR_SATURATE_EN, 16'h52F8 without.
REQ-036 data_ready 2 cycles after an accepted sample -> dropped, next out_valid carries err=1, buffer unchanged by the dropped sample.
REQ-037 load_coeff and data_ready in the same IDLE cycle -> LOAD for 4 cycles, coeff_done pulse, sample dropped, next result err=1.
REQ-038 n_rst asserted on MAC cycle 2 -> all outputs 0 immediately, no out_valid; 1000 subsequent samples -> one_k_samples pulses exactly once.

Source files
------------

// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR sequencer slice: controller state encoding,
// default tap count, sample/coefficient widths, the Q1.15 fraction shift and
// the sample-counter wrap value.
// No ports (package).
// ----------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    MAC   = 3'd3,
    DONE  = 3'd4
  } fir_state_e;

  localparam int NUM_TAPS_DEF = 4;
  localparam int SAMPLE_W     = 16;
  localparam int COEFF_W      = 16;
  localparam int FRAC_SHIFT   = 15;
  localparam int WRAP_COUNT   = 1000;
  localparam int CNT_W        = $clog2(WRAP_COUNT);

endpackage

// File: rtl/fir_sequencer_if.sv
// ----------------------------------------------------------------------------
// fir_sequencer_if
// Groups the sample/coefficient handshake and the result outputs of the FIR
// sequencer.
//   master : the environment (drives samples, coefficients, load request)
//   slave  : fir_sequencer
// Signals: data_ready, sample_data, load_coeff, coeff_in  (master -> slave)
//          coeff_sel, coeff_done, busy, fir_out, out_valid, err,
//          one_k_samples                                  (slave -> master)
// ----------------------------------------------------------------------------
interface fir_sequencer_if
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF
);
  localparam int SEL_W = $clog2(NUM_TAPS);

  logic                data_ready;
  logic [SAMPLE_W-1:0] sample_data;
  logic                load_coeff;
  logic [COEFF_W-1:0]  coeff_in;
  logic [SEL_W-1:0]    coeff_sel;
  logic                coeff_done;
  logic                busy;
  logic [SAMPLE_W-1:0] fir_out;
  logic                out_valid;
  logic                err;
  logic                one_k_samples;

  modport master (
    output data_ready, sample_data, load_coeff, coeff_in,
    input  coeff_sel, coeff_done, busy, fir_out, out_valid, err, one_k_samples
  );

  modport slave (
    input  data_ready, sample_data, load_coeff, coeff_in,
    output coeff_sel, coeff_done, busy, fir_out, out_valid, err, one_k_samples
  );

endinterface

// File: rtl/fir_mac.sv
// ----------------------------------------------------------------------------
// fir_mac
// Multiply-accumulate unit: acc <= clr ? 0 : en ? acc + coeff*sample : acc.
// Ports:
//   clk, n_rst   clock / asynchronous active-low reset
//   clr_i        clear the accumulator
//   en_i         add coeff_i*sample_i (32-bit product) this cycle
//   coeff_i      Q1.15 coefficient
//   sample_i     unsigned sample
//   acc_nxt_o    accumulator value after this cycle's update, so the caller
//                can register a result in the same cycle as the last product
// ----------------------------------------------------------------------------
module fir_mac
  import fir_pkg::*;
#(
  parameter int ACC_W = COEFF_W + SAMPLE_W + 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [COEFF_W-1:0]  coeff_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [ACC_W-1:0]    acc_nxt_o
);
  localparam int PROD_W = COEFF_W + SAMPLE_W;

  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;

  // Product and accumulator next value
  always_comb begin
    prod_s = {{SAMPLE_W{1'b0}}, coeff_i} * {{COEFF_W{1'b0}}, sample_i};
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/fir_sequencer.sv
// ----------------------------------------------------------------------------
// fir_sequencer
// Sequential NUM_TAPS-tap FIR: loads a coefficient set one tap per cycle,
// shifts accepted samples into a delay line and runs one MAC per tap before
// presenting the Q1.15-scaled result.
// Ports:
//   clk     rising-edge clock
//   n_rst   asynchronous active-low reset
//   bus     fir_sequencer_if.slave (samples, coefficients, results, status)
// Build option: define FIR_SATURATE_EN to clamp overflowing results to
// 16'hFFFF; otherwise the low 16 bits of accumulator>>15 are output. err is
// the same in both builds.
// ----------------------------------------------------------------------------
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF
) (
  input  logic           clk,
  input  logic           n_rst,
  fir_sequencer_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_TAPS);
  localparam int ACC_W = COEFF_W + SAMPLE_W + SEL_W;
  localparam int RES_W = ACC_W - FRAC_SHIFT;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WRAP_COUNT - 1);

  fir_state_e          state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] tap_q   [NUM_TAPS];
  logic [COEFF_W-1:0]  coeff_q [NUM_TAPS];
  logic                overrun_q, overrun_d;
  logic                load_pend_q, load_pend_d;
  logic                load_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    coeff_sel_q, coeff_sel_d;
  logic                coeff_done_q, coeff_done_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic                one_k_q, one_k_d;
  logic [SAMPLE_W-1:0] fir_out_q, fir_out_d;
  logic [ACC_W-1:0]    acc_nxt_s;
  logic [RES_W-1:0]    res_s;
  logic                ovf_s;
  logic [SAMPLE_W-1:0] res_out_s;

  fir_mac #(.ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr_i     (state_q == SHIFT),
    .en_i      (state_q == MAC),
    .coeff_i   (coeff_q[idx_q]),
    .sample_i  (tap_q[idx_q]),
    .acc_nxt_o (acc_nxt_s)
  );

  // Scale the final sum and flag results that do not fit in 16 bits
  always_comb begin
    res_s = RES_W'(acc_nxt_s >> FRAC_SHIFT);
    ovf_s = |res_s[RES_W-1:SAMPLE_W];
`ifdef FIR_SATURATE_EN
    if (ovf_s) begin
      res_out_s = {SAMPLE_W{1'b1}};
    end else begin
      res_out_s = res_s[SAMPLE_W-1:0];
    end
`else
    res_out_s = res_s[SAMPLE_W-1:0];
`endif
  end

  // Controller next state, bookkeeping flags and next output values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sample_d    = sample_q;
    overrun_d   = overrun_q;
    load_pend_d = load_pend_q;
    cnt_d       = cnt_q;
    fir_out_d   = fir_out_q;
    err_d       = err_q;
    one_k_d     = 1'b0;

    // Anything arriving while busy: samples are lost, loads are remembered
    if (state_q != IDLE) begin
      if (bus.data_ready) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      if (bus.load_coeff && !load_prev_q) begin
        load_pend_d = 1'b1;
      end else begin
        load_pend_d = load_pend_q;
      end
    end else begin
      overrun_d   = overrun_q;
      load_pend_d = load_pend_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.load_coeff || load_pend_q) begin
          // Coefficient load wins; a coincident sample is lost
          state_d     = LOAD;
          idx_d       = '0;
          load_pend_d = 1'b0;
          if (bus.data_ready) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end else if (bus.data_ready) begin
          state_d  = SHIFT;
          sample_d = bus.sample_data;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            one_k_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            one_k_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (idx_q == LAST_SEL) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = LOAD;
          idx_d   = idx_q + SEL_W'(1);
        end
      end
      SHIFT: begin
        state_d = MAC;
        idx_d   = '0;
      end
      MAC: begin
        if (idx_q == LAST_SEL) begin
          // Last product is in acc_nxt_s, so the result is captured now
          state_d   = DONE;
          idx_d     = '0;
          fir_out_d = res_out_s;
          err_d     = ovf_s | overrun_d;
          overrun_d = 1'b0;
        end else begin
          state_d = MAC;
          idx_d   = idx_q + SEL_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    coeff_sel_d  = (state_d == LOAD) ? idx_d : '0;
    coeff_done_d = (state_d == LOAD) && (idx_d == LAST_SEL);
    busy_d       = (state_d != IDLE);
    out_valid_d  = (state_d == DONE);
  end

  // Controller state, flags and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sample_q     <= '0;
      overrun_q    <= 1'b0;
      load_pend_q  <= 1'b0;
      load_prev_q  <= 1'b0;
      cnt_q        <= '0;
      coeff_sel_q  <= '0;
      coeff_done_q <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      one_k_q      <= 1'b0;
      fir_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      overrun_q    <= overrun_d;
      load_pend_q  <= load_pend_d;
      load_prev_q  <= bus.load_coeff;
      cnt_q        <= cnt_d;
      coeff_sel_q  <= coeff_sel_d;
      coeff_done_q <= coeff_done_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      one_k_q      <= one_k_d;
      fir_out_q    <= fir_out_d;
    end
  end

  // Sample delay line, shifted once per accepted sample
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= '0;
    end else if (state_q == SHIFT) begin
      tap_q[0] <= sample_q;
      for (int k = 1; k < NUM_TAPS; k++) tap_q[k] <= tap_q[k-1];
    end
  end

  // Coefficient registers, written at the index presented on coeff_sel
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) coeff_q[k] <= '0;
    end else if (state_q == LOAD) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (coeff_sel_q == SEL_W'(k)) coeff_q[k] <= bus.coeff_in;
      end
    end
  end

  assign bus.coeff_sel     = coeff_sel_q;
  assign bus.coeff_done    = coeff_done_q;
  assign bus.busy          = busy_q;
  assign bus.fir_out       = fir_out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.err           = err_q;
  assign bus.one_k_samples = one_k_q;

endmodule
